// File: rtl/solver_dispatcher_pkg.sv
// Shared definitions for the solver dispatcher: state encoding and default sizing.
package solver_dispatcher_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int CW_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/solver_dispatcher_cycle_timer.sv
// Up-counting wait timer; terminal flags the last permitted WAIT cycle (count == TIMEOUT-1).
module solver_dispatcher_cycle_timer
  import solver_dispatcher_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign terminal = (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/solver_dispatcher.sv
// Host-side initiator for the expression solver: load operand, start, wait with
// timeout, capture result, reset solver, hand result downstream.
//
// state | meaning
// IDLE  | ready for a new operand
// START | one-cycle solver start pulse
// WAIT  | waiting for completed, timer running
// CLEAR | one-cycle solver reset after capture/abort
// OUT   | result presented until downstream accepts
module solver_dispatcher
  import solver_dispatcher_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  output logic [W-1:0]  sol_x,
  output logic          sol_start,
  input  logic          sol_completed,
  input  logic [W-1:0]  sol_result,
  output logic          sol_rst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic          out_err,
  output logic          busy,
  output logic [CW-1:0] job_count
);

  state_e          state_q, state_d;
  logic [W-1:0]    sol_x_q, sol_x_d;
  logic            sol_start_q, sol_start_d;
  logic            sol_rst_q, sol_rst_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_result_q, out_result_d;
  logic            out_err_q, out_err_d;
  logic [CW-1:0]   job_count_q, job_count_d;
  logic            timer_terminal;

  // Timer only runs in WAIT and is held at zero everywhere else.
  solver_dispatcher_cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q != ST_WAIT),
    .enable   (state_q == ST_WAIT),
    .terminal (timer_terminal)
  );

  always_comb begin
    state_d      = state_q;
    sol_x_d      = sol_x_q;
    sol_start_d  = 1'b0;
    sol_rst_d    = 1'b0;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    job_count_d  = job_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sol_x_d     = in_x;
          sol_start_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (sol_completed) begin
          out_result_d = sol_result;
          out_err_d    = 1'b0;
          job_count_d  = job_count_q + CW'(1);
          sol_rst_d    = 1'b1;
          state_d      = ST_CLEAR;
        end else if (timer_terminal) begin
          out_result_d = '0;
          out_err_d    = 1'b1;
          sol_rst_d    = 1'b1;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sol_x_q      <= '0;
      sol_start_q  <= 1'b0;
      sol_rst_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      job_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sol_x_q      <= sol_x_d;
      sol_start_q  <= sol_start_d;
      sol_rst_q    <= sol_rst_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      job_count_q  <= job_count_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign sol_x      = sol_x_q;
  assign sol_start  = sol_start_q;
  assign sol_rst    = sol_rst_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign job_count  = job_count_q;

endmodule

// File: tb/tb_solver_dispatcher.sv
// Self-checking bench: a solver model answers N cycles after start; a job-level
// reference predicts latency, result, error flag and wrapping job counts.
module tb_solver_dispatcher;

  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int CW      = 8;
  localparam int CW_W    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic          sol_completed = 1'b0;
  logic [W-1:0]  sol_result = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, sol_start, sol_rst, out_valid, out_err, busy;
  logic [W-1:0]  sol_x, out_result;
  logic [CW-1:0] job_count;

  logic            w_in_ready, w_sol_start, w_sol_rst, w_out_valid, w_out_err, w_busy;
  logic [W-1:0]    w_sol_x, w_out_result;
  logic [CW_W-1:0] w_job_count;

  int n_cmp   = 0;
  int n_mis   = 0;
  int jobs_ok = 0;

  always #5 clk = ~clk;

  solver_dispatcher #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .sol_x(sol_x), .sol_start(sol_start), .sol_completed(sol_completed),
    .sol_result(sol_result), .sol_rst(sol_rst), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .busy(busy), .job_count(job_count)
  );

  solver_dispatcher #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW_W)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_x(in_x),
    .sol_x(w_sol_x), .sol_start(w_sol_start), .sol_completed(sol_completed),
    .sol_result(sol_result), .sol_rst(w_sol_rst), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_result(w_out_result), .out_err(w_out_err),
    .busy(w_busy), .job_count(w_job_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counts();
    chk("job_count", 32'(job_count), 32'(jobs_ok % (1 << CW)));
    chk("job_count_cw2", 32'(w_job_count), 32'(jobs_ok % (1 << CW_W)));
  endtask

  task automatic check_reset_vals(input string when);
    chk({when, "_in_ready"},   32'(in_ready),   32'd1);
    chk({when, "_sol_x"},      32'(sol_x),      32'd0);
    chk({when, "_sol_start"},  32'(sol_start),  32'd0);
    chk({when, "_sol_rst"},    32'(sol_rst),    32'd0);
    chk({when, "_out_valid"},  32'(out_valid),  32'd0);
    chk({when, "_out_result"}, 32'(out_result), 32'd0);
    chk({when, "_out_err"},    32'(out_err),    32'd0);
    chk({when, "_busy"},       32'(busy),       32'd0);
    chk({when, "_job_count"},  32'(job_count),  32'd0);
    chk({when, "_job_count_w"}, 32'(w_job_count), 32'd0);
  endtask

  // Called at a negedge with the dispatcher idle. The solver answers n cycles
  // after the cycle in which sol_start is high; it succeeds iff 1 <= n <= TIMEOUT.
  task automatic run_job(input logic [W-1:0] x, input int n, input logic [W-1:0] res,
                         input int bp);
    bit ok;
    int exp_lat, c, starts, rsts, start_at, rst_at;
    bit busy_bad, x_bad, bp_bad;
    logic [W-1:0] exp_res;
    ok       = (n >= 1) && (n <= TIMEOUT);
    exp_lat  = ok ? n + 3 : TIMEOUT + 3;
    exp_res  = ok ? res : '0;
    starts   = 0; rsts = 0; start_at = -1; rst_at = -1;
    busy_bad = 1'b0; x_bad = 1'b0; bp_bad = 1'b0;
    sol_completed = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_x     = x;
    @(negedge clk);
    c = 1;
    in_valid = 1'b0;
    while (!out_valid && c <= TIMEOUT + 10) begin
      if (sol_start) begin starts++; start_at = c; end
      if (sol_rst) begin
        rsts++; rst_at = c;
        sol_completed = 1'b0;
      end else if (c == 1 + n) begin
        sol_completed = 1'b1;
        sol_result    = res;
      end
      if (!sol_completed) sol_result = W'($urandom);
      if (!busy || in_ready) busy_bad = 1'b1;
      if (sol_x !== x) x_bad = 1'b1;
      // Upstream and downstream noise that must be ignored mid-job.
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (ok) jobs_ok++;
    chk("latency",      32'(c),        32'(exp_lat));
    chk("start_pulses", 32'(starts),   32'd1);
    chk("start_cycle",  32'(start_at), 32'd1);
    chk("rst_pulses",   32'(rsts),     32'd1);
    chk("rst_cycle",    32'(rst_at),   32'(exp_lat - 1));
    chk("busy_mid_job", 32'(busy_bad), 32'd0);
    chk("sol_x_held",   32'(x_bad),    32'd0);
    chk("out_valid",    32'(out_valid),  32'd1);
    chk("out_result",   32'(out_result), 32'(exp_res));
    chk("out_err",      32'(out_err),    32'(!ok));
    check_counts();
    for (int i = 0; i < bp; i++) begin
      sol_completed = 1'($urandom_range(0, 1));
      sol_result    = W'($urandom);
      in_valid      = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_valid || out_result !== exp_res || out_err !== !ok || in_ready || !busy
          || sol_start || sol_rst || sol_x !== x) bp_bad = 1'b1;
    end
    chk("backpressure_hold", 32'(bp_bad), 32'd0);
    sol_completed = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_accept_valid",    32'(out_valid), 32'd0);
    chk("post_accept_in_ready", 32'(in_ready),  32'd1);
    chk("post_accept_busy",     32'(busy),      32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    run_job(8'h05, 7, 8'h2A, 0);
    run_job(8'hC3, 3, 8'h99, 10);
    run_job(8'h11, 1000, 8'h55, 2);
    run_job(8'h22, TIMEOUT, 8'h7E, 1);
    run_job(8'h33, TIMEOUT - 1, 8'h81, 0);
    run_job(8'h44, TIMEOUT + 1, 8'hF0, 0);
    run_job(8'h66, 1, 8'h01, 3);

    for (int j = 0; j < 40; j++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT + 1, TIMEOUT + 8))
                                      : int'($urandom_range(1, TIMEOUT));
      run_job(W'($urandom), n, W'($urandom), int'($urandom_range(0, 4)));
    end

    // Abort a job in WAIT with an asynchronous reset, then run a clean job.
    in_valid = 1'b1;
    in_x     = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("midjob_reset");
    jobs_ok = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job(8'h03, 4, 8'h3C, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
